mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Main sequencer for the multicycle RV32I core variant; shares one ALU, one memory port and the register file across the phases of each instruction.
- Takes opcode, funct3 and instr[30] from the instruction register, plus the ALU compare flags.
- Drives every datapath select/enable, a memory request/ready handshake, an illegal-instruction strobe and a retired-instruction counter.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous active-high
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct75  input  1  instr[30]
zero  input  1  ALU result == 0
lt  input  1  signed rs1 < rs2
ltu  input  1  unsigned rs1 < rs2
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access requested
memwrite  output  1  store strobe, qualified by mem_req
adrsrc  output  1  0 = PC, 1 = ALUOut drives the memory address
irwrite  output  1  load instruction register and oldPC
pcwrite  output  1  load PC from result bus
regwrite  output  1  register file write enable
resultsrc  output  2  00 ALUOut, 01 memory data, 10 ALU result
alusrca  output  2  00 PC, 01 oldPC, 10 RD1, 11 zero
alusrcb  output  2  00 RD2, 01 immext, 10 constant 4
alucontrol  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
immsrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal_instr  output  1  one-cycle strobe for an unsupported opcode
instret  output  INSTRET_W  count of completed instructions

Behaviour:
- Reset (asynchronous):
  - State goes to FETCH and instret to 0.
  - While rst is high, mem_req, irwrite, pcwrite, regwrite and memwrite are all 0.
  - Reset mid-instruction abandons the instruction with no write.
- Outputs are Moore per state, except these Mealy terms:
  - pcwrite and irwrite in FETCH: asserted only when mem_ready is high.
  - pcwrite in BRANCH: depends on the branch condition.
- Any select not listed for a state is don't-care; alucontrol defaults to add.
- FETCH:
  - Drives mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10 (PC+4).
  - Holds until mem_ready; on mem_ready asserts irwrite and pcwrite, then goes to DECODE.
- DECODE:
  - Computes branch/jal target: alusrca=01, alusrcb=01; immsrc=B for branch, J otherwise.
  - Next state by opcode:
    - 0000011 load or 0100011 store -> MEMADR
    - 0110011 -> EXECR
    - 0010011 or 0110111 lui -> EXECI
    - 0010111 -> AUIPC
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other opcode -> FETCH, with illegal_instr=1 for this cycle and instret unchanged
- MEMADR: alusrca=10, alusrcb=01, immsrc=I for load or S for store; then MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adrsrc=1; holds until mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1; then FETCH.
- MEMWRITE: mem_req=1, memwrite=1, adrsrc=1; holds until mem_ready, then FETCH.
- EXECR: alusrca=10, alusrcb=00, alucontrol from funct3 (funct75 applies to 000 and 101); then ALUWB.
  - 000: add, or sub if funct75=1
  - 001: sll; 010: slt; 011: sltu; 100: xor
  - 101: srl, or sra if funct75=1
  - 110: or; 111: and
- EXECI: alusrcb=01; then ALUWB.
  - OP-IMM: alusrca=10, immsrc=I, same funct3 decode as EXECR but funct75 ignored for 000.
  - lui: alusrca=11, immsrc=U, add.
- AUIPC: alusrca=01, alusrcb=01, immsrc=U, add; then ALUWB.
- ALUWB: resultsrc=00, regwrite=1; then FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00; then FETCH.
  - pcwrite = taken, where taken by funct3 is:
    - 000: zero; 001: !zero
    - 100: lt; 101: !lt
    - 110: ltu; 111: !ltu
    - 010 or 011: never taken
- JALR: alusrca=10, alusrcb=01, immsrc=I, add; then JAL.
- JAL: pcwrite=1, resultsrc=00 (target), alusrca=01, alusrcb=10 (link = oldPC+4); then ALUWB.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; it wraps at the maximum value.
- Cycle counts with mem_ready tied high:
  - 3 cycles: branch
  - 4 cycles: R-type, I-type, lui, auipc, store, jal
  - 5 cycles: load, jalr
  - Each wait cycle extends the corresponding memory state by 1.

Test Plan:
- add x3,x1,x2 (opcode 0110011, funct3 000, funct75 0), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alucontrol=0000; regwrite high in cycle 4 only; instret 0->1.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD -> mem_req=1 and adrsrc=1 held for 3 cycles; resultsrc=01 with regwrite in MEMWB; 7 cycles total.
- bne (funct3 001): zero=1 -> pcwrite stays 0 in BRANCH; zero=0 -> pcwrite=1 with resultsrc=00; both cases 3 cycles.
- jalr (1100111) -> DECODE, JALR (alusrca=10, alusrcb=01), JAL (pcwrite=1), ALUWB (regwrite=1); instret +1.
- opcode 1111111 -> illegal_instr=1 for one cycle in DECODE, back to FETCH, no regwrite/memwrite, instret unchanged; with instret=0xFFFFFFFF, a completed add wraps it to 0.
- Assert rst while in MEMWRITE waiting on mem_ready -> immediately FETCH, memwrite=0, mem_req=0 while rst high, instret=0; after release mem_req=1 in FETCH.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main sequencer.
// Walks each instruction through fetch, decode and the execute/memory/
// writeback phases, driving every datapath select and enable, the memory
// request handshake, an illegal-opcode strobe and a retired-instruction count.
//
// Memory handshake: mem_req is held high for the whole memory phase
// (FETCH, MEMREAD, MEMWRITE) and the access completes on the rising edge where
// mem_req && mem_ready are both high; the FSM leaves the phase on that edge.
// Address and write strobe are stable while mem_req is high.
module mc_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct75,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 memwrite,
  output logic                 adrsrc,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 regwrite,
  output logic [1:0]           resultsrc,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [3:0]           alucontrol,
  output logic [2:0]           immsrc,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_AUIPC    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;
  logic                 taken;
  logic                 mem_req_raw, memwrite_raw, irwrite_raw, pcwrite_raw;
  logic                 regwrite_raw, illegal_raw;

  // funct3 -> ALU operation; sub_sra selects sub/sra where the encoding allows it
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  alu_dec = sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  // branch condition from funct3 and the ALU compare flags
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // next state and per-state datapath controls
  always_comb begin
    state_d      = state_q;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    immsrc       = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = (opcode == OP_BRANCH) ? IMM_B : IMM_J;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM, OP_LUI:    state_d = S_EXECI;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        immsrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        adrsrc      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_raw  = 1'b1;
        memwrite_raw = 1'b1;
        adrsrc       = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b00;
        alucontrol = alu_dec(funct3, funct75);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        alusrcb = 2'b01;
        if (opcode == OP_LUI) begin
          alusrca = 2'b11;
          immsrc  = IMM_U;
        end else begin
          alusrca    = 2'b10;
          alucontrol = alu_dec(funct3, (funct3 == 3'b101) & funct75);
        end
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 2'b10;
        alusrcb     = 2'b00;
        alucontrol  = ALU_SUB;
        pcwrite_raw = taken;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        pcwrite_raw = 1'b1;
        alusrca     = 2'b01;
        alusrcb     = 2'b10;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // an instruction retires on the edge that returns to FETCH after its last phase
  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
             ((state_q == S_MEMWRITE) && mem_ready);
    instret_d = retire ? instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1} : instret_q;
  end

  // state and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // architectural side effects are suppressed while reset is held
  assign mem_req       = mem_req_raw  & ~rst;
  assign memwrite      = memwrite_raw & ~rst;
  assign irwrite       = irwrite_raw  & ~rst;
  assign pcwrite       = pcwrite_raw  & ~rst;
  assign regwrite      = regwrite_raw & ~rst;
  assign illegal_instr = illegal_raw  & ~rst;
  assign instret       = instret_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios with literal expectations,
// then randomized instruction streams checked every cycle against a
// phase-list model of each instruction.
module tb_mc_control_fsm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic         funct75 = 1'b0;
  logic         zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic         mem_ready = 1'b0;
  logic         mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0]   resultsrc, alusrca, alusrcb;
  logic [3:0]   alucontrol;
  logic [2:0]   immsrc;
  logic         illegal_instr;
  logic [W-1:0] instret;
  logic [3:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.INSTRET_W(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct75(funct75),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
    .pcwrite(pcwrite), .regwrite(regwrite), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .immsrc(immsrc), .illegal_instr(illegal_instr), .instret(instret),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct75 = f75;
  endtask

  // ---------------- reference model ----------------
  string        ph_q[$];
  string        cur_ph = "FETCH";
  logic [W-1:0] m_instret = '0;
  logic [6:0]   m_op;
  logic [2:0]   m_f3;
  logic         m_f75;

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f75);
    case (f3)
      3'd0: alu_of = f75 ? 4'd1 : 4'd0;
      3'd1: alu_of = 4'd7;
      3'd2: alu_of = 4'd5;
      3'd3: alu_of = 4'd6;
      3'd4: alu_of = 4'd4;
      3'd5: alu_of = f75 ? 4'd9 : 4'd8;
      3'd6: alu_of = 4'd3;
      default: alu_of = 4'd2;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'd0: br_taken = z;
      3'd1: br_taken = !z;
      3'd4: br_taken = l;
      3'd5: br_taken = !l;
      3'd6: br_taken = lu;
      3'd7: br_taken = !lu;
      default: br_taken = 1'b0;
    endcase
  endfunction

  // phases an instruction goes through after FETCH
  task automatic load_phases(input logic [6:0] op);
    ph_q.delete();
    ph_q.push_back("DECODE");
    case (op)
      7'b0000011: begin ph_q.push_back("MEMADR"); ph_q.push_back("MEMREAD"); ph_q.push_back("MEMWB"); end
      7'b0100011: begin ph_q.push_back("MEMADR"); ph_q.push_back("MEMWRITE"); end
      7'b0110011: begin ph_q.push_back("EXECR"); ph_q.push_back("ALUWB"); end
      7'b0010011, 7'b0110111: begin ph_q.push_back("EXECI"); ph_q.push_back("ALUWB"); end
      7'b0010111: begin ph_q.push_back("AUIPC"); ph_q.push_back("ALUWB"); end
      7'b1100011: ph_q.push_back("BRANCH");
      7'b1101111: begin ph_q.push_back("JAL"); ph_q.push_back("ALUWB"); end
      7'b1100111: begin ph_q.push_back("JALR"); ph_q.push_back("JAL"); ph_q.push_back("ALUWB"); end
      default: ;
    endcase
  endtask

  task automatic pick_instr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: m_op = 7'b0000011;
      1: m_op = 7'b0100011;
      2: m_op = 7'b0110011;
      3: m_op = 7'b0010011;
      4: m_op = 7'b0110111;
      5: m_op = 7'b0010111;
      6: m_op = 7'b1100011;
      7: m_op = 7'b1101111;
      8: m_op = 7'b1100111;
      default: m_op = 7'($urandom_range(0, 127));
    endcase
    m_f3  = 3'($urandom_range(0, 7));
    m_f75 = 1'($urandom_range(0, 1));
  endtask

  // expected outputs for the current phase and inputs, compared against the DUT
  task automatic compare_cycle();
    logic e_req, e_mw, e_ir, e_pc, e_rw, e_ill;
    logic [3:0] e_alu;
    e_req = 0; e_mw = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_ill = 0;
    e_alu = 4'd0;
    case (cur_ph)
      "FETCH": begin
        e_req = 1; e_ir = mem_ready; e_pc = mem_ready;
        chk("fetch_adrsrc", adrsrc, 0); chk("fetch_srca", alusrca, 0);
        chk("fetch_srcb", alusrcb, 2); chk("fetch_res", resultsrc, 2);
      end
      "DECODE": begin
        e_ill = !is_legal(m_op);
        chk("dec_srca", alusrca, 1); chk("dec_srcb", alusrcb, 1);
        chk("dec_imm", immsrc, (m_op == 7'b1100011) ? 3 'd2 : 3'd3);
      end
      "MEMADR": begin
        chk("ma_srca", alusrca, 2); chk("ma_srcb", alusrcb, 1);
        chk("ma_imm", immsrc, (m_op == 7'b0100011) ? 3'd1 : 3'd0);
      end
      "MEMREAD":  begin e_req = 1; chk("mr_adrsrc", adrsrc, 1); end
      "MEMWB":    begin e_rw = 1; chk("mwb_res", resultsrc, 1); end
      "MEMWRITE": begin e_req = 1; e_mw = 1; chk("mw_adrsrc", adrsrc, 1); end
      "EXECR": begin
        e_alu = alu_of(m_f3, m_f75);
        chk("er_srca", alusrca, 2); chk("er_srcb", alusrcb, 0);
      end
      "EXECI": begin
        chk("ei_srcb", alusrcb, 1);
        if (m_op == 7'b0110111) begin
          chk("lui_srca", alusrca, 3); chk("lui_imm", immsrc, 4);
        end else begin
          e_alu = alu_of(m_f3, (m_f3 == 3'd5) && m_f75);
          chk("ei_srca", alusrca, 2); chk("ei_imm", immsrc, 0);
        end
      end
      "AUIPC": begin
        chk("au_srca", alusrca, 1); chk("au_srcb", alusrcb, 1); chk("au_imm", immsrc, 4);
      end
      "ALUWB": begin e_rw = 1; chk("awb_res", resultsrc, 0); end
      "BRANCH": begin
        e_alu = 4'd1; e_pc = br_taken(m_f3, zero, lt, ltu);
        chk("br_srca", alusrca, 2); chk("br_srcb", alusrcb, 0); chk("br_res", resultsrc, 0);
      end
      "JALR": begin
        chk("jr_srca", alusrca, 2); chk("jr_srcb", alusrcb, 1); chk("jr_imm", immsrc, 0);
      end
      "JAL": begin
        e_pc = 1;
        chk("jal_srca", alusrca, 1); chk("jal_srcb", alusrcb, 2); chk("jal_res", resultsrc, 0);
      end
      default: chk("model_phase_known", 0, 1);
    endcase
    chk("mem_req", mem_req, e_req);
    chk("memwrite", memwrite, e_mw);
    chk("irwrite", irwrite, e_ir);
    chk("pcwrite", pcwrite, e_pc);
    chk("regwrite", regwrite, e_rw);
    chk("illegal_instr", illegal_instr, e_ill);
    chk("alucontrol", alucontrol, e_alu);
    chk("instret", instret, m_instret);
  endtask

  // model phase transition taken at the coming rising edge
  task automatic advance_model();
    if ((cur_ph == "FETCH" || cur_ph == "MEMREAD" || cur_ph == "MEMWRITE") && !mem_ready) return;
    if (cur_ph == "FETCH") begin
      pick_instr();
      load_phases(m_op);
      cur_ph = ph_q.pop_front();
    end else if (ph_q.size() == 0) begin
      if (is_legal(m_op)) m_instret = m_instret + 1'b1;
      cur_ph = "FETCH";
    end else begin
      cur_ph = ph_q.pop_front();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset held: side-effect strobes low, counter cleared
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_pcwrite", pcwrite, 0);
    chk("rst_instret", instret, 0);
    cyc(); cyc();
    rst = 1'b0;

    // add x3,x1,x2 with memory always ready: 4 cycles, instret 0 -> 1
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("add_fetch_req", mem_req, 1); chk("add_fetch_ir", irwrite, 1);
    chk("add_fetch_pc", pcwrite, 1); chk("add_fetch_res", resultsrc, 2);
    cyc(); chk("add_dec_rw", regwrite, 0); chk("add_dec_req", mem_req, 0);
    cyc(); chk("add_ex_alu", alucontrol, 4'b0000); chk("add_ex_rw", regwrite, 0);
    cyc(); chk("add_wb_rw", regwrite, 1); chk("add_wb_res", resultsrc, 0);
    cyc(); chk("add_done_instret", instret, 1); chk("add_done_req", mem_req, 1);

    // bne not taken (zero=1) then taken (zero=0), 3 cycles each
    set_instr(7'b1100011, 3'b001, 1'b0);
    zero = 1'b1;
    cyc(); chk("bne_dec_imm", immsrc, 3'b010);
    cyc(); chk("bne_nt_pc", pcwrite, 0); chk("bne_alu", alucontrol, 4'b0001);
    cyc(); chk("bne_nt_instret", instret, 2); chk("bne_nt_req", mem_req, 1);
    zero = 1'b0;
    cyc();
    cyc(); chk("bne_t_pc", pcwrite, 1); chk("bne_t_res", resultsrc, 0);
    cyc(); chk("bne_t_instret", instret, 3); chk("bne_t_req", mem_req, 1);

    // illegal opcode: one-cycle strobe, no write, count unchanged
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc(); chk("ill_strobe", illegal_instr, 1); chk("ill_rw", regwrite, 0); chk("ill_mw", memwrite, 0);
    cyc(); chk("ill_clear", illegal_instr, 0); chk("ill_instret", instret, 3); chk("ill_fetch_req", mem_req, 1);

    // lw with two wait cycles in MEMREAD: 7 cycles total
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(); cyc(); chk("lw_ma_imm", immsrc, 0);
    cyc(); mem_ready = 1'b0; #1; chk("lw_mr1_req", mem_req, 1); chk("lw_mr1_adr", adrsrc, 1);
    cyc(); chk("lw_mr2_req", mem_req, 1); chk("lw_mr2_adr", adrsrc, 1);
    cyc(); mem_ready = 1'b1; #1; chk("lw_mr3_req", mem_req, 1); chk("lw_mr3_adr", adrsrc, 1);
    cyc(); chk("lw_wb_res", resultsrc, 1); chk("lw_wb_rw", regwrite, 1);
    cyc(); chk("lw_instret", instret, 4); chk("lw_fetch_req", mem_req, 1);

    // store abandoned by reset while waiting in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(); cyc(); chk("sw_ma_imm", immsrc, 1);
    cyc(); mem_ready = 1'b0; #1; chk("sw_mw", memwrite, 1); chk("sw_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("sw_rst_mw", memwrite, 0); chk("sw_rst_req", mem_req, 0); chk("sw_rst_instret", instret, 0);
    cyc(); chk("sw_rst_hold_req", mem_req, 0);
    rst = 1'b0;
    #1;
    chk("sw_rel_req", mem_req, 1); chk("sw_rel_instret", instret, 0);

    // randomized instruction stream against the model (counter wraps at 2^W)
    cur_ph = "FETCH";
    m_instret = '0;
    m_op = opcode; m_f3 = funct3; m_f75 = funct75;
    for (int c = 0; c < 4000; c++) begin
      opcode = m_op; funct3 = m_f3; funct75 = m_f75;
      mem_ready = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom_range(0, 1));
      lt   = 1'($urandom_range(0, 1));
      ltu  = 1'($urandom_range(0, 1));
      #1;
      compare_cycle();
      advance_model();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
